nios_system_multi_timer: RTL and testbench
==========================================

Name: nios_system_multi_timer

Overview:
- Parametrised N-channel interval timer on one Avalon-MM slave; successor to the single-channel HAL system timer.
- Per channel: CNT_W-bit down-counter, programmable prescaler, one-shot/continuous mode, snapshot and timeout status.
- One combined level irq to the Nios II; a pending-vector register identifies the channel(s) without polling each one.

Parameters:
- NUM_CH, 4, number of timer channels (1..2**CH_W).
- CH_W, 2, channel-select address bits.
- CNT_W, 32, counter/period width (1..32).
- PRE_W, 8, prescaler width (1..16).
- RESET_PERIOD, 49999, reset value of every period register and counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  CH_W+3  {channel, reg[2:0]}.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  OR over channels of (TO & ITO).

Behaviour:
- Register map per channel (reg field):
  - 0 STATUS: bit0 TO, bit1 RUN; any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP. Bits 1:0 are stored. START/STOP are write-only pulses and read 0.
  - 2 PERIOD: CNT_W bits.
  - 3 SNAP: write captures the counter; read returns the captured value.
  - 4 PRESCALE: PRE_W bits.
  - 7 IRQ_PEND: read-only NUM_CH-bit vector of TO&ITO. Same value from any channel's reg 7.
  - 5, 6 and channels >= NUM_CH: read 0, writes ignored.
  - Unused high bits read 0; writedata is truncated to field width.
- Reset values: all counters and PERIOD = RESET_PERIOD; CONTROL, PRESCALE, SNAP, TO, RUN = 0; readdata = 0; irq = 0.
- Read: readdata is registered from the address every clock (chipselect not required); 1-cycle latency; no wait states.
- Write: takes effect on the edge where chipselect & ~write_n.
- Prescaler, per channel:
  - pre_cnt decrements each clock while RUN.
  - tick = RUN & (pre_cnt == 0); on tick, pre_cnt reloads PRESCALE.
  - PRESCALE = 0 gives a tick every clock.
  - START reloads pre_cnt with PRESCALE.
- Counter on each tick:
  - count != 0: count - 1.
  - count == 0: reload PERIOD, set TO. If CONT = 0, clear RUN on the same edge.
  - Period P therefore yields (P+1)*(PRESCALE+1) clocks between timeouts.
- PERIOD write: register updates on the write edge. On the following edge, the counter loads the new PERIOD and RUN clears. The channel stays stopped until START.
- START: sets RUN; counter resumes from its current value with no reload. START on a running channel only reloads the prescaler.
- STOP: clears RUN; counter holds its value.
- START and STOP in the same write: START wins.
- TO set (timeout) and STATUS write in the same cycle: set wins, so no event is lost.
- SNAP write in the same cycle as a decrement captures the pre-edge count.
- irq is combinational from registered TO/ITO, so it never glitches from the bus. Clearing ITO drops irq but keeps TO.
- Channels are fully independent; simultaneous timeouts on several channels each set their own TO.
- Asynchronous reset mid-count returns every channel to reset state immediately; irq drops with reset asserted.

Test Plan:
- Reset, then read ch0 PERIOD, STATUS, CONTROL -> readdata 49999, 0, 0, one cycle after address.
- ch1: PERIOD=9, PRESCALE=0, CONTROL=0x7 (ITO|CONT|START) -> TO and irq first set 10 clocks after START. Write STATUS: TO clears; re-sets 10 clocks later. IRQ_PEND reads 0x2.
- ch2: PERIOD=3, PRESCALE=4, CONTROL=0x5 (one-shot) -> TO at 20 clocks, RUN=0 on the same edge, counter holds 3.
- ch0 running with PERIOD=100: write PERIOD=5 mid-count -> RUN=0 next edge, counter=5. SNAP write then read returns 5.
- Timeout coincident with a STATUS write on ch3 -> TO remains 1. A CONTROL write of 0xC -> RUN=1.
- Assert reset_n while ch1 irq=1 -> irq=0 and readdata=0 immediately; after release, ch1 STATUS reads 0.

Source files
------------

// File: rtl/nios_system_multi_timer.sv
// N-channel interval timer on a single Avalon-MM slave with a combined irq.
// Each channel has a down-counter, prescaler, one-shot/continuous mode, snapshot and pending status.
module nios_system_multi_timer #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CH_W         = 2,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned PRE_W        = 8,
    parameter int unsigned RESET_PERIOD = 49999
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [CH_W+2:0] address,
    input  logic            chipselect,
    input  logic            write_n,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    output logic            irq
);

    logic [CH_W-1:0]              sel_ch;
    logic [2:0]                   reg_sel;
    logic                         wr_en;
    logic [NUM_CH-1:0]            pend;
    logic [NUM_CH-1:0][31:0]      ch_rd;
    logic [31:0]                  rd_next;

    assign sel_ch  = address[CH_W+2:3];
    assign reg_sel = address[2:0];
    assign wr_en   = chipselect && !write_n;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] snap;
        logic [PRE_W-1:0] pre_cnt;
        logic [PRE_W-1:0] prescale;
        logic             to;
        logic             run;
        logic             ito;
        logic             cont;
        logic             reload_pend;
        logic             tick;
        logic             wr_hit;
        logic [31:0]      rd_val;

        assign wr_hit = wr_en && (sel_ch == CH_W'(g));
        assign tick   = run && (pre_cnt == '0);

        // Statement order sets priority: timeout beats STATUS clear,
        // PERIOD reload beats the tick, START beats STOP and the reload's run clear.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                count       <= CNT_W'(RESET_PERIOD);
                period      <= CNT_W'(RESET_PERIOD);
                snap        <= '0;
                pre_cnt     <= '0;
                prescale    <= '0;
                to          <= 1'b0;
                run         <= 1'b0;
                ito         <= 1'b0;
                cont        <= 1'b0;
                reload_pend <= 1'b0;
            end else begin
                if (wr_hit && reg_sel == 3'd0) begin
                    to <= 1'b0;
                end

                if (tick) begin
                    pre_cnt <= prescale;
                    if (count == '0) begin
                        count <= period;
                        to    <= 1'b1;
                        if (!cont) begin
                            run <= 1'b0;
                        end
                    end else begin
                        count <= count - 1'b1;
                    end
                end else if (run) begin
                    pre_cnt <= pre_cnt - 1'b1;
                end

                if (reload_pend) begin
                    count       <= period;
                    run         <= 1'b0;
                    reload_pend <= 1'b0;
                end

                if (wr_hit) begin
                    case (reg_sel)
                        3'd1: begin
                            ito  <= writedata[0];
                            cont <= writedata[1];
                            if (writedata[2]) begin
                                run     <= 1'b1;
                                pre_cnt <= prescale;
                            end else if (writedata[3]) begin
                                run <= 1'b0;
                            end
                        end
                        3'd2: begin
                            period      <= writedata[CNT_W-1:0];
                            reload_pend <= 1'b1;
                        end
                        3'd3:    snap     <= count;
                        3'd4:    prescale <= writedata[PRE_W-1:0];
                        default: ;
                    endcase
                end
            end
        end

        always_comb begin
            rd_val = '0;
            case (reg_sel)
                3'd0:    rd_val = 32'({run, to});
                3'd1:    rd_val = 32'({cont, ito});
                3'd2:    rd_val = 32'(period);
                3'd3:    rd_val = 32'(snap);
                3'd4:    rd_val = 32'(prescale);
                default: rd_val = '0;
            endcase
        end

        assign ch_rd[g] = rd_val;
        assign pend[g]  = to & ito;
    end

    always_comb begin
        rd_next = '0;
        if (reg_sel == 3'd7) begin
            rd_next = 32'(pend);
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (32'(sel_ch) == i) begin
                    rd_next = ch_rd[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    assign irq = |pend;

endmodule

// File: tb/tb_nios_system_multi_timer.sv
// Directed bench for nios_system_multi_timer: register access, timing, priorities and reset.
module tb_nios_system_multi_timer;

    logic        clk;
    logic        reset_n;
    logic [4:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int unsigned n_checks;
    int unsigned n_fail;
    logic [31:0] rd;

    nios_system_multi_timer #(
        .NUM_CH(4),
        .CH_W(2),
        .CNT_W(32),
        .PRE_W(8),
        .RESET_PERIOD(49999)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic bus_write(input logic [1:0] ch, input logic [2:0] rg, input logic [31:0] data);
        address    = {ch, rg};
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] ch, input logic [2:0] rg, output logic [31:0] data);
        address = {ch, rg};
        @(negedge clk);
        data = readdata;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        #1;
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        bus_read(2'd0, 3'd2, rd); check("ch0_period_rst", rd, 32'd49999);
        bus_read(2'd0, 3'd0, rd); check("ch0_status_rst", rd, 32'h0);
        bus_read(2'd0, 3'd1, rd); check("ch0_control_rst", rd, 32'h0);

        // ch1: continuous, period 9, no prescale -> 10 clocks between timeouts
        bus_write(2'd1, 3'd2, 32'd9);
        bus_write(2'd1, 3'd4, 32'd0);
        bus_write(2'd1, 3'd1, 32'h7);
        repeat (9) @(negedge clk);
        check("ch1_irq_before", 32'(irq), 32'h0);
        @(negedge clk);
        check("ch1_irq_first", 32'(irq), 32'h1);
        bus_write(2'd1, 3'd0, 32'h0);
        check("ch1_irq_cleared", 32'(irq), 32'h0);
        repeat (8) @(negedge clk);
        check("ch1_irq_before2", 32'(irq), 32'h0);
        @(negedge clk);
        check("ch1_irq_second", 32'(irq), 32'h1);
        bus_read(2'd1, 3'd7, rd); check("ch1_pend", rd, 32'h2);
        bus_read(2'd3, 3'd7, rd); check("pend_from_ch3", rd, 32'h2);

        // ch2: one-shot, period 3, prescale 4 -> timeout 20 clocks after START
        bus_write(2'd2, 3'd2, 32'd3);
        bus_write(2'd2, 3'd4, 32'd4);
        bus_write(2'd2, 3'd1, 32'h5);
        address = {2'd2, 3'd0};
        repeat (20) @(negedge clk);
        check("ch2_status_t19", readdata, 32'h2);
        @(negedge clk);
        check("ch2_status_t20", readdata, 32'h1);
        bus_write(2'd2, 3'd3, 32'h0);
        bus_read(2'd2, 3'd3, rd); check("ch2_snap_hold", rd, 32'd3);

        // ch0: PERIOD rewrite mid-count reloads counter and stops the channel
        bus_write(2'd0, 3'd2, 32'd100);
        bus_write(2'd0, 3'd4, 32'd0);
        bus_write(2'd0, 3'd1, 32'h4);
        repeat (10) @(negedge clk);
        bus_write(2'd0, 3'd2, 32'd5);
        address = {2'd0, 3'd0};
        @(negedge clk);
        check("ch0_run_at_write", readdata, 32'h2);
        @(negedge clk);
        check("ch0_run_after", readdata, 32'h0);
        bus_write(2'd0, 3'd3, 32'h0);
        bus_read(2'd0, 3'd3, rd); check("ch0_snap", rd, 32'd5);
        bus_read(2'd0, 3'd2, rd); check("ch0_period", rd, 32'd5);

        // ch3: STATUS write coincident with a timeout keeps TO
        bus_write(2'd3, 3'd2, 32'd2);
        bus_write(2'd3, 3'd4, 32'd0);
        bus_write(2'd3, 3'd1, 32'h6);
        repeat (2) @(negedge clk);
        bus_write(2'd3, 3'd0, 32'h0);
        bus_read(2'd3, 3'd0, rd); check("ch3_to_kept", rd, 32'h3);
        bus_write(2'd3, 3'd1, 32'h8);
        bus_read(2'd3, 3'd0, rd); check("ch3_stopped", rd, 32'h1);
        bus_write(2'd3, 3'd1, 32'hC);
        bus_read(2'd3, 3'd0, rd); check("ch3_start_wins", rd, 32'h3);
        bus_read(2'd3, 3'd1, rd); check("ch3_control_rd", rd, 32'h0);
        bus_read(2'd3, 3'd7, rd); check("pend_multi", rd, 32'h6);

        // Clearing ITO drops the pending bit but keeps TO
        bus_write(2'd2, 3'd1, 32'h0);
        bus_read(2'd2, 3'd7, rd); check("pend_ito_clr", rd, 32'h2);
        bus_read(2'd2, 3'd0, rd); check("ch2_to_kept", rd, 32'h1);

        bus_write(2'd0, 3'd4, 32'h1FF);
        bus_read(2'd0, 3'd4, rd); check("prescale_trunc", rd, 32'hFF);
        bus_write(2'd0, 3'd5, 32'hDEAD);
        bus_read(2'd0, 3'd5, rd); check("reg5_zero", rd, 32'h0);
        bus_read(2'd0, 3'd6, rd); check("reg6_zero", rd, 32'h0);

        // Asynchronous reset while ch1 irq is high
        address = {2'd1, 3'd2};
        @(negedge clk);
        check("irq_before_rst", 32'(irq), 32'h1);
        reset_n = 1'b0;
        #1;
        check("irq_in_rst", 32'(irq), 32'h0);
        check("readdata_in_rst", readdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd1, 3'd0, rd); check("ch1_status_post", rd, 32'h0);
        bus_read(2'd1, 3'd2, rd); check("ch1_period_post", rd, 32'd49999);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
